// File: rtl/screen_mux_sync_if.sv
// screen_mux_sync_if: source buses, selection request and registered output of the screen multiplexer.
interface screen_mux_sync_if #(
   parameter int N_SRC = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 11,
   parameter int RGB_W = 12
);
   logic [SEL_W-1:0]       sel_req;
   logic [N_SRC*CNT_W-1:0] src_hcount;
   logic [N_SRC*CNT_W-1:0] src_vcount;
   logic [N_SRC-1:0]       src_hsync;
   logic [N_SRC-1:0]       src_vsync;
   logic [N_SRC-1:0]       src_hblnk;
   logic [N_SRC-1:0]       src_vblnk;
   logic [N_SRC*RGB_W-1:0] src_rgb;
   logic [CNT_W-1:0]       out_hcount;
   logic [CNT_W-1:0]       out_vcount;
   logic                   out_hsync;
   logic                   out_vsync;
   logic                   out_hblnk;
   logic                   out_vblnk;
   logic [RGB_W-1:0]       out_rgb;
   logic [SEL_W-1:0]       active_sel;
   logic                   switching;
   modport master (
      output sel_req, src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb,
      input  out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb, active_sel, switching
   );
   modport slave (
      input  sel_req, src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb,
      output out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb, active_sel, switching
   );
endinterface

// File: rtl/screen_mux_sync.sv
// screen_mux_sync: N-source VGA screen multiplexer; selection changes only at a frame boundary.
// Define SCREEN_MUX_BLANK_EN to show BLANK_FRAMES black frames between the old and new screen.
module screen_mux_sync #(
   parameter int N_SRC        = 4,
   parameter int SEL_W        = 2,
   parameter int CNT_W        = 11,
   parameter int RGB_W        = 12,
   parameter int BLANK_FRAMES = 2
) (
   input logic              clk,
   input logic              rst,
   screen_mux_sync_if.slave bus
);
   typedef enum logic [1:0] {
      SHOW,
      PEND
`ifdef SCREEN_MUX_BLANK_EN
      , BLANK
`endif
   } state_t;
   state_t           state, state_nx;
   logic [SEL_W-1:0] act, act_nx, pend, pend_nx, mux_idx;
   logic             sw, sw_nx, vb_q, fb, valid, blank;
`ifdef SCREEN_MUX_BLANK_EN
   logic [3:0]       frame_cnt, frame_nx;
`endif
   if (N_SRC < 2 || BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_bad_param
      $error("screen_mux_sync: illegal parameters");
   end
   assign valid          = int'(bus.sel_req) < N_SRC;
   assign fb             = bus.src_vblnk[0] & ~vb_q;
   assign bus.active_sel = act;
   assign bus.switching  = sw;
`ifdef SCREEN_MUX_BLANK_EN
   assign blank   = state == BLANK;
   assign mux_idx = blank ? pend : act;
`else
   assign blank   = 1'b0;
   assign mux_idx = act;
`endif
   // A new request always wins over a coincident frame boundary; the commit waits for a later one.
   always_comb begin
      state_nx = state;
      act_nx   = act;
      pend_nx  = pend;
      sw_nx    = sw;
`ifdef SCREEN_MUX_BLANK_EN
      frame_nx = frame_cnt;
`endif
      case (state)
         SHOW:
            if (valid && bus.sel_req != act) begin
               pend_nx  = bus.sel_req;
               sw_nx    = 1'b1;
               state_nx = PEND;
            end
         PEND:
            if (valid && bus.sel_req == act) begin
               sw_nx    = 1'b0;
               state_nx = SHOW;
            end else if (valid && bus.sel_req != pend) begin
               pend_nx = bus.sel_req;
            end else if (fb) begin
`ifdef SCREEN_MUX_BLANK_EN
               frame_nx = 4'(BLANK_FRAMES - 1);
               state_nx = BLANK;
`else
               act_nx   = pend;
               sw_nx    = 1'b0;
               state_nx = SHOW;
`endif
            end
`ifdef SCREEN_MUX_BLANK_EN
         BLANK:
            if (valid && bus.sel_req != pend) begin
               pend_nx = bus.sel_req;
            end else if (fb) begin
               if (frame_cnt == 4'd0) begin
                  act_nx   = pend;
                  sw_nx    = 1'b0;
                  state_nx = SHOW;
               end else begin
                  frame_nx = frame_cnt - 4'd1;
               end
            end
`endif
         default: state_nx = SHOW;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state          <= SHOW;
         act            <= '0;
         pend           <= '0;
         sw             <= 1'b0;
         vb_q           <= 1'b0;
`ifdef SCREEN_MUX_BLANK_EN
         frame_cnt      <= '0;
`endif
         bus.out_hcount <= '0;
         bus.out_vcount <= '0;
         bus.out_hsync  <= 1'b0;
         bus.out_vsync  <= 1'b0;
         bus.out_hblnk  <= 1'b0;
         bus.out_vblnk  <= 1'b0;
         bus.out_rgb    <= '0;
      end else begin
         state          <= state_nx;
         act            <= act_nx;
         pend           <= pend_nx;
         sw             <= sw_nx;
         vb_q           <= bus.src_vblnk[0];
`ifdef SCREEN_MUX_BLANK_EN
         frame_cnt      <= frame_nx;
`endif
         bus.out_hcount <= bus.src_hcount[mux_idx*CNT_W +: CNT_W];
         bus.out_vcount <= bus.src_vcount[mux_idx*CNT_W +: CNT_W];
         bus.out_hsync  <= bus.src_hsync[mux_idx];
         bus.out_vsync  <= bus.src_vsync[mux_idx];
         bus.out_hblnk  <= bus.src_hblnk[mux_idx];
         bus.out_vblnk  <= bus.src_vblnk[mux_idx];
         bus.out_rgb    <= blank ? '0 : bus.src_rgb[mux_idx*RGB_W +: RGB_W];
      end
endmodule
